// File: rtl/loader_pkg.sv
// Shared types and helpers for the program loader.
package loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  // Number of whole bytes needed to carry one instruction word.
  function automatic int bytes_per_word(input int instr_sz);
    return (instr_sz + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/program_loader_instr_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB-first and
// flags the byte that completes a word.
module instr_assembler
  import loader_pkg::*;
#(
  parameter int WORD_W = 24,
  parameter int NBYTES = 3
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  localparam int SR_W  = NBYTES * BYTE_W;
  localparam int CNT_W = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Completion is flagged on the accepting cycle so the FSM can leave
  // RECV without an idle cycle.
  assign word_full_o = shift_i && (cnt_q == LAST);
  // Upper bits of the first byte beyond the word width fall off here.
  assign word_o      = sr_q[WORD_W-1:0];

  // Next-state for shift register and byte counter.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[SR_W-BYTE_W-1:0], byte_i};
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: streams bytes into instruction RAM and holds the CPU
// in reset until the whole image has been written.
module program_loader
  import loader_pkg::*;
#(
  parameter  int N             = 8,
  parameter  int AddrSz        = 6,
  localparam int InstructionSz = N + 16,
  localparam int BytesPerWord  = bytes_per_word(InstructionSz)
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic [AddrSz:0]          length,
  input  logic [BYTE_W-1:0]        byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [AddrSz-1:0]        wr_addr,
  output logic [InstructionSz-1:0] wr_data,
  output logic                     cpu_hold,
  output logic                     done
);

  localparam logic [AddrSz:0] LEN_MAX = {1'b1, {AddrSz{1'b0}}};

  loader_state_t     state_q, state_d;
  logic [AddrSz:0]   len_q, len_d, len_sat;
  logic [AddrSz:0]   words_q, words_d, words_inc;
  logic [AddrSz-1:0] addr_q, addr_d;
  logic              byte_ready_q, wr_en_q, done_q, cpu_hold_q;
  logic              asm_clr, asm_shift, word_full;

  assign len_sat   = (length > LEN_MAX) ? LEN_MAX : length;
  assign words_inc = words_q + 1'b1;
  // Only the registered ready qualifies a byte, so a byte presented
  // alongside start is taken no earlier than the next cycle.
  assign asm_shift = byte_valid && byte_ready_q;

  instr_assembler #(
    .WORD_W (InstructionSz),
    .NBYTES (BytesPerWord)
  ) u_asm (
    .clk         (clk),
    .n_reset     (n_reset),
    .clr_i       (asm_clr),
    .shift_i     (asm_shift),
    .byte_i      (byte_data),
    .word_o      (wr_data),
    .word_full_o (word_full)
  );

  // FSM and counter next-state.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    asm_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          asm_clr = 1'b1;
          words_d = '0;
          addr_d  = '0;
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d   = len_sat;
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Address wraps to 0 after a full 2^AddrSz image.
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        state_d = (words_inc == len_q) ? ST_DONE : ST_RECV;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      words_q      <= '0;
      addr_q       <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      byte_ready_q <= (state_d == ST_RECV);
      wr_en_q      <= (state_d == ST_WRITE);
      done_q       <= (state_d == ST_DONE);
      cpu_hold_q   <= (state_d != ST_DONE);
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;

endmodule
